// File: rtl/adder_seq_pkg.sv
// -----------------------------------------------------------------------------
// adder_seq_pkg
// Shared definitions for the time-shared nibble adder block:
//   - state_t   : FSM states of adder_seq_arb (IDLE, CALC, RESP)
//   - NIB_W     : width of the shared adder slice (4 bits)
//   - NUM_REQ   : number of requesters sharing the adder (2)
//   - add_nibble: the 4-bit slice itself (A + B + Cin -> {Cout, Sum})
// No ports; imported by the interface, the arbiter and the top.
// -----------------------------------------------------------------------------
package adder_seq_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      RESP = 2'd2
   } state_t;

   localparam int NIB_W   = 4;
   localparam int NUM_REQ = 2;

   // One nibble of addition; bit 4 of the result is the carry-out that
   // feeds the next nibble.
   function automatic logic [NIB_W:0] add_nibble(input logic [NIB_W-1:0] a,
                                                  input logic [NIB_W-1:0] b,
                                                  input logic             c);
      return {1'b0, a} + {1'b0, b} + {{NIB_W{1'b0}}, c};
   endfunction

endpackage

// File: rtl/adder_seq_arb_if.sv
// -----------------------------------------------------------------------------
// adder_seq_arb_if
// Request/response bundle of adder_seq_arb.
//   req_valid/req_ready [1:0]     : per-requester handshake
//   req_a/req_b [2*WIDTH-1:0]     : operands, requester i at [i*WIDTH +: WIDTH]
//   req_cin [1:0]                 : per-requester carry-in
//   req_sub [1:0]                 : subtract select (only with ADDER_SEQ_ARB_SUB_EN)
//   rsp_valid/rsp_ready           : result handshake
//   rsp_id, rsp_sum, rsp_cout     : result owner, sum and final carry
// Modports: master = requesters + result consumer, slave = the adder.
// -----------------------------------------------------------------------------
interface adder_seq_arb_if
   import adder_seq_pkg::*;
#(
   parameter int WIDTH = 16
);

   logic [NUM_REQ-1:0]       req_valid;
   logic [NUM_REQ-1:0]       req_ready;
   logic [NUM_REQ*WIDTH-1:0] req_a;
   logic [NUM_REQ*WIDTH-1:0] req_b;
   logic [NUM_REQ-1:0]       req_cin;
`ifdef ADDER_SEQ_ARB_SUB_EN
   logic [NUM_REQ-1:0]       req_sub;
`endif
   logic                     rsp_valid;
   logic                     rsp_ready;
   logic                     rsp_id;
   logic [WIDTH-1:0]         rsp_sum;
   logic                     rsp_cout;

`ifdef ADDER_SEQ_ARB_SUB_EN
   modport master (
      output req_valid, req_a, req_b, req_cin, req_sub, rsp_ready,
      input  req_ready, rsp_valid, rsp_id, rsp_sum, rsp_cout
   );

   modport slave (
      input  req_valid, req_a, req_b, req_cin, req_sub, rsp_ready,
      output req_ready, rsp_valid, rsp_id, rsp_sum, rsp_cout
   );
`else
   modport master (
      output req_valid, req_a, req_b, req_cin, rsp_ready,
      input  req_ready, rsp_valid, rsp_id, rsp_sum, rsp_cout
   );

   modport slave (
      input  req_valid, req_a, req_b, req_cin, rsp_ready,
      output req_ready, rsp_valid, rsp_id, rsp_sum, rsp_cout
   );
`endif

endinterface

// File: rtl/adder_seq_arb_rr_arb2.sv
// -----------------------------------------------------------------------------
// rr_arb2
// Two-way round-robin arbiter.
//   clk, rst_n : clock, asynchronous active-low reset
//   req[1:0]   : request lines
//   advance    : a grant was consumed this cycle; remember who got it
//   grant[1:0] : one-hot grant, or zero when nobody requests
// After reset requester 0 wins a tie.
// -----------------------------------------------------------------------------
module rr_arb2 (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [1:0] req,
   input  logic       advance,
   output logic [1:0] grant
);

   logic last_one;

   // Lone requester always wins; on a tie the requester that was not
   // served last wins. last_one starts at 1 so requester 0 has priority
   // out of reset.
   always_comb begin
      grant = 2'b00;
      if (req[0] && (!req[1] || last_one)) begin
         grant = 2'b01;
      end else if (req[1]) begin
         grant = 2'b10;
      end
   end

   // The pointer only moves when a grant is actually accepted, so a
   // requester that is granted but not yet transferred keeps its turn.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_one <= 1'b1;
      end else if (advance && (grant != 2'b00)) begin
         last_one <= grant[1];
      end
   end

endmodule

// File: rtl/adder_seq_arb.sv
// -----------------------------------------------------------------------------
// adder_seq_arb
// Two requesters share one 4-bit adder slice. An accepted operation is
// added one nibble per cycle, LSB nibble first, then held as a response
// until the consumer takes it.
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset, drops any in-flight operation
//   bus   : adder_seq_arb_if.slave (request and response handshakes)
//   WIDTH : operand width, multiple of 4 from 4 to 64
// Optional feature: define ADDER_SEQ_ARB_SUB_EN to add per-requester
// req_sub (A - B, rsp_cout = 1 meaning no borrow).
// -----------------------------------------------------------------------------
module adder_seq_arb
   import adder_seq_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic           clk,
   input  logic           rst_n,
   adder_seq_arb_if.slave bus
);

   localparam int NIBS = WIDTH / NIB_W;

   state_t               state;
   logic [WIDTH-1:0]     op_a;
   logic [WIDTH-1:0]     op_b;
   logic [WIDTH-1:0]     sum_q;
   logic                 carry;
   logic [4:0]           nib_cnt;
   logic                 rsp_valid_q;
   logic                 rsp_id_q;
   logic                 rsp_cout_q;

   logic [NUM_REQ-1:0]   grant;
   logic                 handshake;
   logic                 sel;
   logic [WIDTH-1:0]     a_in;
   logic [WIDTH-1:0]     b_in;
   logic                 cin_in;
   logic [NIB_W:0]       slice;
   logic [WIDTH+NIB_W-1:0] sum_shift;

   rr_arb2 u_arb (
      .clk     (clk),
      .rst_n   (rst_n),
      .req     (bus.req_valid),
      .advance (handshake),
      .grant   (grant)
   );

   assign bus.req_ready = (state == IDLE) ? grant : 2'b00;
   assign handshake     = |(bus.req_valid & bus.req_ready);
   assign sel           = grant[1];

   assign a_in = sel ? bus.req_a[WIDTH +: WIDTH] : bus.req_a[0 +: WIDTH];

   // Subtraction is A + ~B + 1, so the inversion and the forced carry are
   // applied once at capture time and the nibble loop stays a plain adder.
`ifdef ADDER_SEQ_ARB_SUB_EN
   logic sub_in;
   assign sub_in = bus.req_sub[sel];
   assign b_in   = sub_in ? ~(sel ? bus.req_b[WIDTH +: WIDTH] : bus.req_b[0 +: WIDTH])
                          :  (sel ? bus.req_b[WIDTH +: WIDTH] : bus.req_b[0 +: WIDTH]);
   assign cin_in = sub_in ? 1'b1 : bus.req_cin[sel];
`else
   assign b_in   = sel ? bus.req_b[WIDTH +: WIDTH] : bus.req_b[0 +: WIDTH];
   assign cin_in = bus.req_cin[sel];
`endif

   // The slice always works on the low nibble of the shifting operand
   // registers; each new sum nibble enters at the top of sum_q so that after
   // NIBS shifts the first nibble has reached bit 0.
   assign slice     = add_nibble(op_a[NIB_W-1:0], op_b[NIB_W-1:0], carry);
   assign sum_shift = {slice[NIB_W-1:0], sum_q};

   assign bus.rsp_valid = rsp_valid_q;
   assign bus.rsp_id    = rsp_id_q;
   assign bus.rsp_sum   = sum_q;
   assign bus.rsp_cout  = rsp_cout_q;

   // Main FSM: IDLE captures a granted request, CALC runs one nibble per
   // cycle for exactly NIBS cycles, RESP holds the result until rsp_ready.
   // Leaving RESP always goes through IDLE, so no request is accepted in the
   // same cycle a response completes.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         op_a        <= '0;
         op_b        <= '0;
         sum_q       <= '0;
         carry       <= 1'b0;
         nib_cnt     <= '0;
         rsp_valid_q <= 1'b0;
         rsp_id_q    <= 1'b0;
         rsp_cout_q  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (handshake) begin
                  op_a     <= a_in;
                  op_b     <= b_in;
                  carry    <= cin_in;
                  rsp_id_q <= sel;
                  nib_cnt  <= '0;
                  state    <= CALC;
               end
            end
            CALC: begin
               op_a    <= op_a >> NIB_W;
               op_b    <= op_b >> NIB_W;
               sum_q   <= sum_shift[WIDTH+NIB_W-1:NIB_W];
               carry   <= slice[NIB_W];
               nib_cnt <= nib_cnt + 5'd1;
               if (nib_cnt == 5'(NIBS - 1)) begin
                  rsp_cout_q  <= slice[NIB_W];
                  rsp_valid_q <= 1'b1;
                  state       <= RESP;
               end
            end
            RESP: begin
               if (bus.rsp_ready) begin
                  rsp_valid_q <= 1'b0;
                  state       <= IDLE;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: doc/adder_seq_arb.md
ADDER_SEQ_ARB -- requirements
Module: adder_seq_arb

Interface
REQ-001 SHALL have parameter WIDTH, default 16, operand width in bits; legal values are multiples of 4 from 4 to 64.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port req_valid  input  2  per-requester request valid; bit i belongs to requester i.
REQ-005 SHALL have port req_ready  output  2  per-requester accept; a request transfers when valid and ready are both high on a clk edge.
REQ-006 SHALL have port req_a  input  2*WIDTH  operand A; requester i occupies bits [i*WIDTH +: WIDTH].
REQ-007 SHALL have port req_b  input  2*WIDTH  operand B; same packing as req_a.
REQ-008 SHALL have port req_cin  input  2  per-requester carry-in.
REQ-009 SHALL have port rsp_valid  output  1  result valid.
REQ-010 SHALL have port rsp_ready  input  1  result consumer accept.
REQ-011 SHALL have port rsp_id  output  1  index of the requester owning the result.
REQ-012 SHALL have port rsp_sum  output  WIDTH  sum.
REQ-013 SHALL have port rsp_cout  output  1  carry-out of the most significant nibble.

Function
REQ-014 SHALL time-share one 4-bit adder slice (A, B, Cin -> 4-bit sum, Cout) between both requesters, adding one nibble per cycle, LSB nibble first.
REQ-015 SHALL implement FSM states IDLE, CALC, RESP; IDLE->CALC on handshake, CALC->RESP after the last nibble, RESP->IDLE on rsp_valid && rsp_ready.
REQ-016 SHALL drive req_ready high only in IDLE, and only for the granted requester; req_ready is zero in CALC and RESP.
REQ-017 SHALL arbitrate round-robin: with one requester valid, grant it; with both valid, grant the one not granted last; after reset requester 0 has priority.
REQ-018 SHALL register operands, cin and requester index on handshake; later changes to req_* do not affect an accepted operation.
REQ-019 SHALL spend exactly WIDTH/4 cycles in CALC, feeding the slice the registered carry from the previous nibble (req_cin for nibble 0).
REQ-020 SHALL assert rsp_valid on the cycle after the final CALC cycle; handshake-to-rsp_valid latency is WIDTH/4+1 cycles.
REQ-021 SHALL hold rsp_valid, rsp_id, rsp_sum, rsp_cout stable while rsp_ready is low.
REQ-022 SHALL not accept a new request in the cycle rsp completes; next acceptance earliest the following cycle (IDLE).
REQ-023 SHALL produce rsp_sum = (A+B+cin) mod 2^WIDTH and rsp_cout = bit WIDTH of that sum, including full carry ripple across all nibbles.

Reset
REQ-024 SHALL on rst_n low, immediately and regardless of state: FSM=IDLE, rsp_valid=0, rsp_id=0, rsp_sum=0, rsp_cout=0, carry register=0, nibble counter=0, RR pointer favours requester 0.
REQ-025 SHALL discard any in-flight operation on reset; no response is produced for it.

Configuration
REQ-026 SHALL, with macro ADDER_SEQ_ARB_SUB_EN defined, add port req_sub  input  2  per-requester subtract select; when set, slice B input is the inverted nibble and nibble-0 carry-in is 1 (req_cin ignored), giving A-B with rsp_cout=1 meaning no borrow.
REQ-027 SHALL, without ADDER_SEQ_ARB_SUB_EN, have no req_sub port and perform addition only.

Structure
REQ-028 SHALL place FSM state enum, nibble width constant (4) and requester-count constant (2) in shared package adder_seq_pkg.
REQ-029 SHALL implement the arbiter as sub-module rr_arb2 (inputs req[1:0], advance; output grant[1:0], one-hot or zero).

Verification
REQ-030 SHALL cover: req0 A=0x0000 B=0x0000 cin=0 -> rsp_sum=0x0000, rsp_cout=0, rsp_id=0, rsp_valid 5 cycles after handshake.
REQ-031 SHALL cover: req1 A=0x0004 B=0x0005 cin=1 -> rsp_sum=0x000A, rsp_cout=0, rsp_id=1.
REQ-032 SHALL cover: A=0xFFFF B=0x0001 cin=0 -> rsp_sum=0x0000, rsp_cout=1 (ripple through all 4 nibbles); A=0x000A B=0x000B -> 0x0015.
REQ-033 SHALL cover: both req_valid held high for 4 requests -> rsp_id sequence 0,1,0,1.
REQ-034 SHALL cover: rsp_ready low 10 cycles -> outputs stable, req_ready=00 throughout; rst_n pulsed mid-CALC -> rsp_valid stays 0, next request completes correctly.
REQ-035 SHALL cover (ADDER_SEQ_ARB_SUB_EN): A=0x000A B=0x000B sub=1 -> rsp_sum=0xFFFF, rsp_cout=0.
